ofs_plat_axi_mem_sink_ram: RTL

//  AXI4 memory sink (responder) backed by an internal RAM; terminates the sink end of an AXI mem link.

---
 rtl/ofs_plat_axi_mem_sink_ram.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/ofs_plat_axi_mem_sink_ram.sv
// AXI4 memory responder backed by an internal RAM. Independent write (AW/W/B) and read (AR/R)
// engines, each with a single burst in flight; all bursts are INCR with full-width beats.
module ofs_plat_axi_mem_sink_ram #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,

  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,

  input  logic                    wvalid,
  output logic                    wready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,

  output logic                    bvalid,
  input  logic                    bready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,

  input  logic                    arvalid,
  output logic                    arready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,

  output logic                    rvalid,
  input  logic                    rready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned Offs  = $clog2(StrbW);
  localparam int unsigned WordW = ADDR_WIDTH - Offs;
  localparam int unsigned Depth = 2 ** WordW;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic       R_IDLE = 1'b0;
  localparam logic       R_DATA = 1'b1;

  logic [DATA_WIDTH-1:0] mem [Depth];

  logic [1:0]       w_state;
  logic [WordW-1:0] w_addr;
  logic [7:0]       w_len;
  logic [7:0]       w_cnt;
  logic             w_err;
  logic             w_beat;

  logic             r_state;
  logic [WordW-1:0] r_addr;
  logic [7:0]       r_len;
  logic [7:0]       r_cnt;
  logic             r_done;
  logic             r_adv;
  logic             r_rd;

  assign wready = (w_state == W_DATA);
  assign bvalid = (w_state == W_RESP);
  assign bresp  = w_err ? 2'b10 : 2'b00;
  assign w_beat = wvalid && wready;
  assign rresp  = 2'b00;

  // Termination is by beat count; a misplaced wlast only flags SLVERR.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
      bid     <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          awready <= 1'b1;
          if (awvalid && awready) begin
            awready <= 1'b0;
            w_state <= W_DATA;
            bid     <= awid;
            w_addr  <= awaddr[ADDR_WIDTH-1:Offs];
            w_len   <= awlen;
            w_cnt   <= '0;
            w_err   <= 1'b0;
          end
        end
        W_DATA: begin
          if (w_beat) begin
            w_addr <= w_addr + 1'b1;
            w_cnt  <= w_cnt + 8'd1;
            if (wlast != (w_cnt == w_len)) w_err <= 1'b1;
            if (w_cnt == w_len) w_state <= W_RESP;
          end
        end
        W_RESP: begin
          if (bready) begin
            w_state <= W_IDLE;
            awready <= 1'b1;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Output register advances when empty or being consumed; r_done marks all words fetched.
  assign r_adv = (r_state == R_DATA) && (!rvalid || rready);
  assign r_rd  = r_adv && !r_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rid     <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          arready <= 1'b1;
          if (arvalid && arready) begin
            arready <= 1'b0;
            r_state <= R_DATA;
            rid     <= arid;
            r_addr  <= araddr[ADDR_WIDTH-1:Offs];
            r_len   <= arlen;
            r_cnt   <= '0;
            r_done  <= 1'b0;
          end
        end
        R_DATA: begin
          if (r_adv) begin
            rvalid <= r_rd;
            rlast  <= r_rd && (r_cnt == r_len);
            if (r_rd) begin
              r_addr <= r_addr + 1'b1;
              r_cnt  <= r_cnt + 8'd1;
              if (r_cnt == r_len) r_done <= 1'b1;
            end
          end
          if (rvalid && rready && rlast) begin
            r_state <= R_IDLE;
            arready <= 1'b1;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Read and write share one block so a same-word collision returns the old word.
  always_ff @(posedge clk) begin
    if (r_rd) rdata <= mem[r_addr];
    if (w_beat) begin
      for (int i = 0; i < int'(StrbW); i++) begin
        if (wstrb[i]) mem[w_addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule
